// File: rtl/uart_pkg.sv
// Shared constants for the beacon UART transmitter: parity and mode codes,
// FSM state encodings and the parity helper.
package uart_pkg;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_ODD  = 1;
    localparam int PARITY_EVEN = 2;

    localparam logic MODE_COUNTER = 1'b0;
    localparam logic MODE_STREAM  = 1'b1;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic [2:0] ST_STOP   = 3'd4;

    // Payload is zero-extended to 9 bits, which leaves its ones count unchanged.
    function automatic logic parity_bit(input logic [8:0] data, input int kind);
        return (kind == PARITY_ODD) ? ~(^data) : (^data);
    endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period clock-enable counter: bit_end marks the last clk cycle of each
// UART bit; restart holds the count at zero so a frame starts on a clean bit.
module uart_bit_timer #(
    parameter int CLKS_PER_BIT = 625
) (
    input  logic clk,
    input  logic reset,
    input  logic restart,
    output logic bit_end
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    logic [CW-1:0] cnt;

    assign bit_end = !restart && (cnt == CW'(CLKS_PER_BIT - 1));

    always_ff @(posedge clk) begin
        if (reset || restart) begin
            cnt <= '0;
        end else if (bit_end) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/uart_beacon_tx.sv
// UART transmitter with a built-in scheduler: periodic incrementing beacon
// frames in counter mode, or bytes taken from a valid/ready stream.
module uart_beacon_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT  = 625,
    parameter int DATA_BITS     = 8,
    parameter int PARITY        = 0,
    parameter int STOP_BITS     = 1,
    parameter int PERIOD_CYCLES = 20000
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic                 mode,
    input  logic [DATA_BITS-1:0] s_data,
    input  logic                 s_valid,
    output logic                 s_ready,
    output logic                 tx,
    output logic                 busy,
    output logic                 frame_done,
    output logic                 overrun,
    output logic [15:0]          tx_count
);

    localparam int PW      = (PERIOD_CYCLES > 1) ? $clog2(PERIOD_CYCLES) : 1;
    localparam bit HAS_PAR = (PARITY != PARITY_NONE);

    logic [2:0]           state, state_n;
    logic [DATA_BITS-1:0] data_q, data_n;
    logic [DATA_BITS-1:0] beacon;
    logic [3:0]           bit_idx, bit_idx_n;
    logic [PW-1:0]        timer;
    logic [15:0]          data_pad;
    logic                 pending, pending_n;
    logic                 s_ready_n, tx_n;
    logic                 accept, take, req, last_stop;
    logic                 restart, bit_end, par_n;

    assign restart = (state == ST_IDLE);

    uart_bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_bit_timer (
        .clk    (clk),
        .reset  (reset),
        .restart(restart),
        .bit_end(bit_end)
    );

    // Stream handshake: a byte transfers on any cycle where s_valid and
    // s_ready are both high; s_valid must hold s_data stable until then.
    always_comb begin
        state_n   = state;
        data_n    = data_q;
        bit_idx_n = bit_idx;
        take      = 1'b0;
        last_stop = 1'b0;
        accept    = s_valid && s_ready;

        case (state)
            ST_IDLE: begin
                if (accept) begin
                    state_n = ST_START;
                    data_n  = s_data;
                end else if (enable && pending) begin
                    state_n = ST_START;
                    data_n  = beacon;
                    take    = 1'b1;
                end
            end
            ST_START: begin
                if (bit_end) begin
                    state_n   = ST_DATA;
                    bit_idx_n = '0;
                end
            end
            ST_DATA: begin
                if (bit_end) begin
                    if (bit_idx == 4'(DATA_BITS - 1)) begin
                        state_n   = HAS_PAR ? ST_PARITY : ST_STOP;
                        bit_idx_n = '0;
                    end else begin
                        bit_idx_n = bit_idx + 4'd1;
                    end
                end
            end
            ST_PARITY: begin
                if (bit_end) begin
                    state_n   = ST_STOP;
                    bit_idx_n = '0;
                end
            end
            ST_STOP: begin
                if (bit_end) begin
                    if (bit_idx == 4'(STOP_BITS - 1)) begin
                        state_n   = ST_IDLE;
                        last_stop = 1'b1;
                    end else begin
                        bit_idx_n = bit_idx + 4'd1;
                    end
                end
            end
            default: state_n = ST_IDLE;
        endcase

        req       = enable && (mode == MODE_COUNTER) && (timer == PW'(PERIOD_CYCLES - 1));
        pending_n = (pending && !take) || req;
        s_ready_n = (state_n == ST_IDLE) && enable && (mode == MODE_STREAM) && !pending_n;

        // tx is registered from next-state values so the pin never glitches.
        data_pad = 16'(data_n);
        par_n    = parity_bit(9'(data_n), PARITY);
        case (state_n)
            ST_START:  tx_n = 1'b0;
            ST_DATA:   tx_n = data_pad[bit_idx_n];
            ST_PARITY: tx_n = par_n;
            default:   tx_n = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            data_q     <= '0;
            bit_idx    <= '0;
            timer      <= '0;
            pending    <= 1'b0;
            overrun    <= 1'b0;
            beacon     <= '0;
            tx         <= 1'b1;
            s_ready    <= 1'b0;
            frame_done <= 1'b0;
            tx_count   <= '0;
        end else begin
            state      <= state_n;
            data_q     <= data_n;
            bit_idx    <= bit_idx_n;
            pending    <= pending_n;
            s_ready    <= s_ready_n;
            tx         <= tx_n;
            frame_done <= last_stop;
            if (req && pending && !take) begin
                overrun <= 1'b1;
            end
            if (!enable || (mode == MODE_STREAM) || (timer == PW'(PERIOD_CYCLES - 1))) begin
                timer <= '0;
            end else begin
                timer <= timer + 1'b1;
            end
            if (last_stop) begin
                beacon   <= beacon + 1'b1;
                tx_count <= tx_count + 16'd1;
            end
        end
    end

    assign busy = (state != ST_IDLE);

endmodule
